// File: rtl/i2s_tx_serializer.sv
// Stereo I2S (Philips) transmitter running directly on the bit clock.
// A one-entry buffer holds the next left/right pair. The frame counter loads
// that pair into the shift words at the start of every frame. Serial data
// trails LRCLK by one BCLK, MSB first, and unused slot bits are zero.
module i2s_tx_serializer #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] s_left,
    input  logic [SAMPLE_WIDTH-1:0] s_right,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    frame_start,
    output logic                    underrun,
    input  logic                    underrun_clr
);

    localparam int            FRAME   = 2 * SLOT_WIDTH;
    localparam int            CW      = $clog2(FRAME);
    localparam logic [CW-1:0] CNT_MAX = CW'(FRAME - 1);
    localparam logic [CW-1:0] SLOT_C  = CW'(SLOT_WIDTH);

    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_next;
    logic                    run;
    logic                    pending_valid;
    logic                    pending_valid_next;
    logic [SAMPLE_WIDTH-1:0] pending_left;
    logic [SAMPLE_WIDTH-1:0] pending_right;
    logic [SAMPLE_WIDTH-1:0] active_left;
    logic [SAMPLE_WIDTH-1:0] active_right;
    logic [SAMPLE_WIDTH-1:0] right_next;
    logic                    accept;
    logic                    load;
    logic                    right_load;

    // Counter advance and the per-edge events derived from it.
    always_comb begin
        cnt_next           = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        accept             = s_valid & s_ready;
        load               = enable & (cnt == CNT_MAX);
        right_load         = enable & (cnt == SLOT_C - 1'b1);
        pending_valid_next = pending_valid;
        if (accept) begin
            pending_valid_next = 1'b1;
        end else if (load) begin
            pending_valid_next = 1'b0;
        end
    end

    // Frame counter, parked at the last slot position while disabled so the
    // first enabled edge always begins a fresh frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= CNT_MAX;
            run <= 1'b0;
        end else begin
            cnt <= enable ? cnt_next : CNT_MAX;
            run <= enable;
        end
    end

    // One-entry input buffer; ready is registered, so a pair accepted on
    // one edge can never be replaced before the next frame consumes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_valid <= 1'b0;
            pending_left  <= '0;
            pending_right <= '0;
            s_ready       <= 1'b0;
        end else begin
            pending_valid <= pending_valid_next;
            s_ready       <= ~pending_valid_next;
            if (accept) begin
                pending_left  <= s_left;
                pending_right <= s_right;
            end
        end
    end

    // Shift words. The right word is staged in right_next so that the
    // previous right LSB is still on the wire during cnt = 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_left  <= '0;
            active_right <= '0;
            right_next   <= '0;
        end else begin
            if (load) begin
                active_left <= pending_valid ? pending_left : '0;
                right_next  <= pending_valid ? pending_right : '0;
            end
            if (right_load) begin
                active_right <= right_next;
            end
        end
    end

    // Sticky underrun; a new empty load beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun <= 1'b0;
        end else begin
            underrun <= (load & ~pending_valid) | (underrun & ~underrun_clr);
        end
    end

    // Serial output, one BCLK behind the slot boundary.
    always_comb begin
        logic [CW-1:0]           p;
        logic [CW-1:0]           j;
        logic                    second_half;
        logic [SAMPLE_WIDTH-1:0] word_sh;
        p           = (cnt == '0) ? CNT_MAX : cnt - 1'b1;
        second_half = (p >= SLOT_C);
        j           = second_half ? p - SLOT_C : p;
        word_sh     = (second_half ? active_right : active_left) << j;
        lrclk       = run & (cnt >= SLOT_C);
        sdata       = run & word_sh[SAMPLE_WIDTH-1];
        frame_start = run & (cnt == '0);
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: 24/32 instance for the main
// sequences, 32/32 instance for the right-LSB wrap case.
module tb_i2s_tx_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [23:0] s_left, s_right;
    logic        s_valid;
    logic        s_ready;
    logic        lrclk, sdata, frame_start, underrun;
    logic        underrun_clr;

    logic        enable1;
    logic [31:0] s_left1, s_right1;
    logic        s_valid1;
    logic        s_ready1, lrclk1, sdata1, frame_start1, underrun1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    i2s_tx_serializer #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_left(s_left), .s_right(s_right), .s_valid(s_valid), .s_ready(s_ready),
        .lrclk(lrclk), .sdata(sdata), .frame_start(frame_start),
        .underrun(underrun), .underrun_clr(underrun_clr)
    );

    i2s_tx_serializer #(.SAMPLE_WIDTH(32), .SLOT_WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .enable(enable1),
        .s_left(s_left1), .s_right(s_right1), .s_valid(s_valid1), .s_ready(s_ready1),
        .lrclk(lrclk1), .sdata(sdata1), .frame_start(frame_start1),
        .underrun(underrun1), .underrun_clr(1'b0)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks one 64-cycle frame starting in the cnt = 0 cycle.
    // Bits 1..24 carry the left word, 33..56 the right word, all else zero.
    task automatic run_frame(input logic [23:0] l, input logic [23:0] r,
                             input bit feed, input logic [23:0] nl, input logic [23:0] nr,
                             input bit ur, input bit clr_end);
        for (int c = 0; c < 64; c++) begin
            logic eb;
            eb = 1'b0;
            if (c >= 1 && c <= 24) eb = l[24-c];
            else if (c >= 33 && c <= 56) eb = r[56-c];
            check_val($sformatf("lrclk c=%0d", c), {31'b0, lrclk}, {31'b0, c >= 32});
            check_val($sformatf("sdata c=%0d", c), {31'b0, sdata}, {31'b0, eb});
            check_val($sformatf("frame_start c=%0d", c), {31'b0, frame_start}, {31'b0, c == 0});
            check_val($sformatf("underrun c=%0d", c), {31'b0, underrun}, {31'b0, ur});
            check_val($sformatf("s_ready c=%0d", c), {31'b0, s_ready}, {31'b0, !(feed && c >= 1)});
            s_valid = 1'b0;
            if (feed && c == 0) begin
                s_left  = nl;
                s_right = nr;
                s_valid = 1'b1;
            end
            if (clr_end && c == 63) underrun_clr = 1'b1;
            tick();
        end
        s_valid      = 1'b0;
        underrun_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] l32, r32;
        rst = 1'b1; enable = 1'b0; s_valid = 1'b0; underrun_clr = 1'b0;
        s_left = '0; s_right = '0;
        enable1 = 1'b0; s_valid1 = 1'b0; s_left1 = '0; s_right1 = '0;

        tick(); tick();
        check_val("rst s_ready", {31'b0, s_ready}, 32'd0);
        check_val("rst lrclk", {31'b0, lrclk}, 32'd0);
        check_val("rst sdata", {31'b0, sdata}, 32'd0);
        check_val("rst frame_start", {31'b0, frame_start}, 32'd0);
        check_val("rst underrun", {31'b0, underrun}, 32'd0);

        rst = 1'b0;
        tick();
        check_val("ready after rst", {31'b0, s_ready}, 32'd1);

        // Pair accepted before enable.
        s_left = 24'hA5A5A5; s_right = 24'h5A5A5A; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check_val("ready full", {31'b0, s_ready}, 32'd0);
        check_val("idle frame_start", {31'b0, frame_start}, 32'd0);

        enable = 1'b1;
        tick();
        // Four back-to-back frames, each feeding the next pair.
        run_frame(24'hA5A5A5, 24'h5A5A5A, 1, 24'h123456, 24'hABCDEF, 0, 0);
        run_frame(24'h123456, 24'hABCDEF, 1, 24'h800001, 24'h7FFFFE, 0, 0);
        run_frame(24'h800001, 24'h7FFFFE, 1, 24'h000FFF, 24'hFFF000, 0, 0);
        run_frame(24'h000FFF, 24'hFFF000, 0, 24'h0, 24'h0, 0, 0);
        // Starved frame: zeros, underrun from cnt=0; clear collides with next set.
        run_frame(24'h0, 24'h0, 0, 24'h0, 24'h0, 1, 1);
        check_val("set beats clr", {31'b0, underrun}, 32'd1);
        check_val("fs after collide", {31'b0, frame_start}, 32'd1);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        check_val("lone clr", {31'b0, underrun}, 32'd0);

        // Buffer a pair, then drop enable at cnt=20.
        s_left = 24'hC3C3C3; s_right = 24'h3C3C3C; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check_val("ready pending E", {31'b0, s_ready}, 32'd0);
        for (int i = 0; i < 18; i++) tick();
        enable = 1'b0;
        tick();
        check_val("dis lrclk", {31'b0, lrclk}, 32'd0);
        check_val("dis sdata", {31'b0, sdata}, 32'd0);
        check_val("dis frame_start", {31'b0, frame_start}, 32'd0);
        check_val("dis pending kept", {31'b0, s_ready}, 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check_val("dis no underrun", {31'b0, underrun}, 32'd0);
        check_val("dis lrclk hold", {31'b0, lrclk}, 32'd0);
        enable = 1'b1;
        tick();
        run_frame(24'hC3C3C3, 24'h3C3C3C, 0, 24'h0, 24'h0, 0, 0);

        // Reset mid-frame with the buffer full.
        check_val("ur before rst", {31'b0, underrun}, 32'd1);
        s_left = 24'h111111; s_right = 24'h222222; s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_val("pre-rst full", {31'b0, s_ready}, 32'd0);
        rst = 1'b1;
        tick();
        check_val("mid rst s_ready", {31'b0, s_ready}, 32'd0);
        check_val("mid rst lrclk", {31'b0, lrclk}, 32'd0);
        check_val("mid rst sdata", {31'b0, sdata}, 32'd0);
        check_val("mid rst frame_start", {31'b0, frame_start}, 32'd0);
        check_val("mid rst underrun", {31'b0, underrun}, 32'd0);
        rst = 1'b0; enable = 1'b0;
        tick();
        check_val("post rst empty", {31'b0, s_ready}, 32'd1);
        enable = 1'b1;
        tick();
        check_val("post rst fs", {31'b0, frame_start}, 32'd1);
        check_val("post rst underrun", {31'b0, underrun}, 32'd1);
        enable = 1'b0;
        tick();

        // 32-bit samples in 32-bit slots: right LSB lands on cnt=0 of next frame.
        l32 = 32'h80000001; r32 = 32'h00000001;
        check_val("w32 ready", {31'b0, s_ready1}, 32'd1);
        s_left1 = l32; s_right1 = r32; s_valid1 = 1'b1;
        tick();
        s_valid1 = 1'b0;
        enable1 = 1'b1;
        tick();
        check_val("w32 fs", {31'b0, frame_start1}, 32'd1);
        check_val("w32 c0 sdata", {31'b0, sdata1}, 32'd0);
        for (int c = 1; c < 64; c++) begin
            logic eb;
            tick();
            eb = (c <= 32) ? l32[32-c] : r32[64-c];
            check_val($sformatf("w32 sdata c=%0d", c), {31'b0, sdata1}, {31'b0, eb});
        end
        tick();
        check_val("w32 wrap fs", {31'b0, frame_start1}, 32'd1);
        check_val("w32 wrap lrclk", {31'b0, lrclk1}, 32'd0);
        check_val("w32 wrap sdata", {31'b0, sdata1}, 32'd1);
        enable1 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Stereo I2S transmitter clocked directly by the PLL-generated bit clock (3.072 MHz, i.e. 64 BCLK per 48 kHz frame).
- Accepts left/right PCM sample pairs over a valid/ready interface and holds them in a one-entry buffer.
- Generates LRCLK and serial data in Philips I2S format: MSB-first, one BCLK delay after each LRCLK edge.
- Sits between the audio sample source (DSP/FIFO) and the codec DACDAT/DACLRCK pins. The codec BCLK pin is driven from the same PLL output.

Parameters:
- SAMPLE_WIDTH, 24, PCM bits per channel; must be ≤ SLOT_WIDTH.
- SLOT_WIDTH, 32, BCLK periods per channel slot; frame length = 2*SLOT_WIDTH.

Ports:
- clk  in  1  bit clock from PLL; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  transmit enable
- s_left  in  SAMPLE_WIDTH  left sample, two's complement
- s_right  in  SAMPLE_WIDTH  right sample
- s_valid  in  1  sample pair valid
- s_ready  out  1  buffer can accept a pair
- lrclk  out  1  word select: 0 = left slot, 1 = right slot
- sdata  out  1  serial data
- frame_start  out  1  one-cycle pulse when cnt = 0
- underrun  out  1  sticky: a frame started with no buffered pair
- underrun_clr  in  1  clears underrun

Behaviour:
- Reset (rst=1 at an edge):
  - cnt = 2*SLOT_WIDTH-1; pending buffer empty; active_left = active_right = 0.
  - Outputs: lrclk=0, sdata=0, frame_start=0, underrun=0, s_ready=0 while rst is high.
- s_ready: registered, equals !pending_valid from the first cycle after reset.
- Accept: s_valid & s_ready at an edge. {s_left, s_right} is written to pending and pending_valid is set. There is no same-edge refill: s_ready stays 0 for the whole cycle in which pending is full.
- Frame counter cnt (0..2*SLOT_WIDTH-1):
  - Increments every edge while enable=1 and wraps 2*SLOT_WIDTH-1 → 0.
  - While enable=0 it is held at 2*SLOT_WIDTH-1. Dropping enable mid-frame abandons the frame; pending is untouched.
- Load event: every edge where cnt becomes 0, including the first enabled edge.
  - If pending is valid: active_left ← pending_left, right_next ← pending_right, pending cleared.
  - Otherwise: active_left ← 0, right_next ← 0, underrun set.
  - active_right ← right_next on the edge where cnt becomes SLOT_WIDTH. This keeps the previous right word alive through cnt=0.
- Output definition, as a function of the registered cnt in the same cycle:
  - lrclk = (cnt ≥ SLOT_WIDTH).
  - p = (cnt-1) mod 2*SLOT_WIDTH; j = p mod SLOT_WIDTH; word = active_left if p < SLOT_WIDTH, else active_right.
  - sdata = word[SAMPLE_WIDTH-1-j] if j < SAMPLE_WIDTH, else 0.
- Disabled: while enable=0, lrclk=0 and sdata=0 are forced, frame_start=0, and there are no loads and no underruns.
- frame_start = 1 exactly when cnt = 0 and enable was high on the edge that produced it.
- underrun flag:
  - Set by an empty load event and held until underrun_clr.
  - If set and clear occur on the same edge, set wins.
  - Accepts into pending continue regardless of enable.
- Latency: a pair accepted at least one edge before a load event is emitted in that frame. Left MSB appears at cnt=1, right MSB at cnt=SLOT_WIDTH+1.

Test Plan:
- Reset, then enable=1 with one pair (0xA5A5A5, 0x5A5A5A) accepted before enable.
  - lrclk low for cnt 0..31 and high for 32..63 (period 64).
  - sdata bits 1..24 = 101001011010010110100101, bits 25..32 = 0.
  - cnt 33..56 serialize 0x5A5A5A MSB-first.
  - frame_start pulses every 64 clocks.
- Back-to-back pairs: present a new pair as soon as s_ready is high; run 4 frames.
  - No underrun.
  - Each frame carries its own pair.
  - s_ready low from accept until the next load edge.
- Starvation: stop s_valid after 1 pair.
  - Second frame outputs all-zero sdata and underrun=1 from the cnt=0 edge.
  - underrun_clr and a simultaneous underrun in the same cycle leaves underrun=1.
  - A lone underrun_clr clears it.
- SAMPLE_WIDTH=SLOT_WIDTH=32, right word 0x00000001: sdata=1 at cnt=0 of the following frame, confirming the right LSB persists across the wrap.
- Drop enable at cnt=20:
  - Next cycle lrclk=0, sdata=0, cnt=63.
  - Pending pair retained.
  - Re-enable: frame_start on the first edge, and the retained pair is emitted.
- Assert rst mid-frame with pending full: next cycle s_ready=0, outputs 0, pending empty, underrun=0, cnt=63.
